// File: rtl/jt10_adpcma_pkg.sv
// Shared types and constants for the ADPCM-A stereo mixer.
package jt10_adpcma_pkg;

   localparam int unsigned CH_NUM_DEF = 6;
   localparam int unsigned ACC_W      = 19;
   localparam int unsigned SMP_W      = 16;
   localparam int unsigned SLOT_W     = 3;

   localparam logic signed [SMP_W-1:0] SMP_MAX = 16'sh7FFF;
   localparam logic signed [SMP_W-1:0] SMP_MIN = 16'sh8000;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_RUN      = 1'b1
   } state_t;

endpackage : jt10_adpcma_pkg

// File: rtl/jt10_adpcma_post.sv
// Converts one 19-bit round total into a 16-bit output sample.
// JT10_ADPCMA_SAT_EN selects unity gain with clamping; otherwise the total is scaled by 1/8.
module jt10_adpcma_post
   import jt10_adpcma_pkg::*;
(
   input  logic signed [ACC_W-1:0] i_total,
   output logic signed [SMP_W-1:0] o_smp_c
);

`ifdef JT10_ADPCMA_SAT_EN
   localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'(SMP_MAX);
   localparam logic signed [ACC_W-1:0] W_MIN = ACC_W'(SMP_MIN);

   always_comb begin
      o_smp_c = i_total[SMP_W-1:0];
      if (i_total > W_MAX) begin
         o_smp_c = SMP_MAX;
      end else if (i_total < W_MIN) begin
         o_smp_c = SMP_MIN;
      end
   end
`else
   // Dropping the three LSBs keeps six full-scale channels within 16 bits.
   logic [ACC_W-SMP_W-1:0] w_unused_lsb;

   assign w_unused_lsb = i_total[ACC_W-SMP_W-1:0];
   assign o_smp_c      = i_total[ACC_W-1 -: SMP_W];
`endif

endmodule : jt10_adpcma_post

// File: rtl/jt10_adpcma_mix.sv
// Sums the time-multiplexed ADPCM-A channels of each round into one stereo sample.
// Output scaling is selected by JT10_ADPCMA_SAT_EN (see jt10_adpcma_post).
module jt10_adpcma_mix
   import jt10_adpcma_pkg::*;
#(
   parameter int unsigned CH_NUM = CH_NUM_DEF
) (
   input  logic                    rst_n,
   input  logic                    clk,
   input  logic                    i_cen,
   input  logic                    i_ch_first,
   input  logic [CH_NUM-1:0]       i_ch_en,
   input  logic signed [SMP_W-1:0] i_pcm_l,
   input  logic signed [SMP_W-1:0] i_pcm_r,
   output logic signed [SMP_W-1:0] o_snd_l,
   output logic signed [SMP_W-1:0] o_snd_r,
   output logic                    o_snd_sample,
   output logic                    o_resync
);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CH_NUM - 1);

   state_t                    r_state,     w_state_nxt;
   logic [SLOT_W-1:0]         r_slot,      w_slot_nxt;
   logic signed [ACC_W-1:0]   r_acc_l,     w_acc_l_nxt;
   logic signed [ACC_W-1:0]   r_acc_r,     w_acc_r_nxt;
   logic signed [SMP_W-1:0]   r_snd_l,     w_snd_l_nxt;
   logic signed [SMP_W-1:0]   r_snd_r,     w_snd_r_nxt;
   logic                      r_sample,    w_sample_nxt;
   logic                      r_resync,    w_resync_nxt;

   logic [SLOT_W-1:0]         w_slot_eff;
   logic signed [ACC_W-1:0]   w_x_l, w_x_r;
   logic signed [ACC_W-1:0]   w_sum_l, w_sum_r;
   logic signed [SMP_W-1:0]   w_post_l, w_post_r;

   // ch_first always re-anchors the current input to slot 0.
   assign w_slot_eff = i_ch_first ? '0 : r_slot;
   assign w_x_l      = i_ch_en[w_slot_eff] ? ACC_W'(i_pcm_l) : '0;
   assign w_x_r      = i_ch_en[w_slot_eff] ? ACC_W'(i_pcm_r) : '0;
   assign w_sum_l    = r_acc_l + w_x_l;
   assign w_sum_r    = r_acc_r + w_x_r;

   jt10_adpcma_post u_post_l (
      .i_total (w_sum_l),
      .o_smp_c (w_post_l)
   );

   jt10_adpcma_post u_post_r (
      .i_total (w_sum_r),
      .o_smp_c (w_post_r)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_UNLOCKED;
         r_slot   <= '0;
         r_acc_l  <= '0;
         r_acc_r  <= '0;
         r_snd_l  <= '0;
         r_snd_r  <= '0;
         r_sample <= 1'b0;
         r_resync <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_slot   <= w_slot_nxt;
         r_acc_l  <= w_acc_l_nxt;
         r_acc_r  <= w_acc_r_nxt;
         r_snd_l  <= w_snd_l_nxt;
         r_snd_r  <= w_snd_r_nxt;
         r_sample <= w_sample_nxt;
         r_resync <= w_resync_nxt;
      end
   end

   // Next-state: lock on ch_first, then accumulate one slot per cen tick.
   always_comb begin
      w_state_nxt  = r_state;
      w_slot_nxt   = r_slot;
      w_acc_l_nxt  = r_acc_l;
      w_acc_r_nxt  = r_acc_r;
      w_snd_l_nxt  = r_snd_l;
      w_snd_r_nxt  = r_snd_r;
      w_sample_nxt = 1'b0;
      w_resync_nxt = 1'b0;

      if (i_cen && (r_state == ST_RUN || i_ch_first)) begin
         w_state_nxt  = ST_RUN;
         w_resync_nxt = (r_state == ST_RUN) && i_ch_first && (r_slot != '0);

         if (w_slot_eff == '0) begin
            w_acc_l_nxt = w_x_l;
            w_acc_r_nxt = w_x_r;
         end else begin
            w_acc_l_nxt = w_sum_l;
            w_acc_r_nxt = w_sum_r;
         end

         if (w_slot_eff == SLOT_LAST) begin
            w_snd_l_nxt  = w_post_l;
            w_snd_r_nxt  = w_post_r;
            w_sample_nxt = 1'b1;
            w_slot_nxt   = '0;
         end else begin
            w_slot_nxt   = w_slot_eff + SLOT_W'(1);
         end
      end
   end

   assign o_snd_l      = r_snd_l;
   assign o_snd_r      = r_snd_r;
   assign o_snd_sample = r_sample;
   assign o_resync     = r_resync;

endmodule : jt10_adpcma_mix

// File: tb/tb_jt10_adpcma_mix.sv
// Self-checking bench for jt10_adpcma_mix: directed cases plus random rounds against a round-level model.
module tb_jt10_adpcma_mix;

   localparam int CH = 6;

   logic               clk;
   logic               rst_n;
   logic               i_cen;
   logic               i_ch_first;
   logic [CH-1:0]      i_ch_en;
   logic signed [15:0] i_pcm_l;
   logic signed [15:0] i_pcm_r;
   logic signed [15:0] o_snd_l;
   logic signed [15:0] o_snd_r;
   logic               o_snd_sample;
   logic               o_resync;

   int n_checks = 0;
   int n_fail   = 0;

   // Round-level model: collect the enabled terms of a round, sum them at the end.
   bit m_run;
   int m_slot;
   int m_lq[$];
   int m_rq[$];
   int m_snd_l, m_snd_r;
   bit m_smp, m_rs;

   jt10_adpcma_mix dut (
      .rst_n        (rst_n),
      .clk          (clk),
      .i_cen        (i_cen),
      .i_ch_first   (i_ch_first),
      .i_ch_en      (i_ch_en),
      .i_pcm_l      (i_pcm_l),
      .i_pcm_r      (i_pcm_r),
      .o_snd_l      (o_snd_l),
      .o_snd_r      (o_snd_r),
      .o_snd_sample (o_snd_sample),
      .o_resync     (o_resync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int post(input int t);
`ifdef JT10_ADPCMA_SAT_EN
      if (t > 32767)  return 32767;
      if (t < -32768) return -32768;
      return t;
`else
      return t >>> 3;
`endif
   endfunction

   function automatic int qsum(input int q[$]);
      int s = 0;
      foreach (q[k]) s += q[k];
      return s;
   endfunction

   task automatic model_reset();
      m_run = 0; m_slot = 0; m_snd_l = 0; m_snd_r = 0; m_smp = 0; m_rs = 0;
      m_lq.delete(); m_rq.delete();
   endtask

   task automatic model_step(input bit cen, input bit first, input logic [CH-1:0] en,
                             input int l, input int r);
      m_smp = 0; m_rs = 0;
      if (!cen) return;
      if (!m_run && !first) return;
      if (first) begin
         if (m_run && m_slot != 0) m_rs = 1;
         m_slot = 0;
         m_run  = 1;
      end
      if (m_slot == 0) begin
         m_lq.delete(); m_rq.delete();
      end
      m_lq.push_back(en[m_slot] ? l : 0);
      m_rq.push_back(en[m_slot] ? r : 0);
      if (m_slot == CH - 1) begin
         m_snd_l = post(qsum(m_lq));
         m_snd_r = post(qsum(m_rq));
         m_smp   = 1;
         m_slot  = 0;
      end else begin
         m_slot++;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".snd_l"},  int'(o_snd_l), m_snd_l);
      chk({tag, ".snd_r"},  int'(o_snd_r), m_snd_r);
      chk({tag, ".sample"}, int'(o_snd_sample), int'(m_smp));
      chk({tag, ".resync"}, int'(o_resync), int'(m_rs));
   endtask

   task automatic step(input string tag, input bit cen, input bit first,
                       input logic [CH-1:0] en, input int l, input int r);
      i_cen      = cen;
      i_ch_first = first;
      i_ch_en    = en;
      i_pcm_l    = 16'(l);
      i_pcm_r    = 16'(r);
      model_step(cen, first, en, l, r);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   function automatic int rnd16();
      logic [15:0] u = 16'($urandom);
      return int'($signed(u));
   endfunction

   initial begin
      int slot_vals[CH];
      rst_n = 1'b0; i_cen = 1'b0; i_ch_first = 1'b0; i_ch_en = '0;
      i_pcm_l = '0; i_pcm_r = '0;
      model_reset();

      // Reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         i_cen = 1'b1; i_ch_first = 1'($urandom); i_ch_en = CH'($urandom);
         i_pcm_l = 16'($urandom); i_pcm_r = 16'($urandom);
         @(posedge clk); #1;
         check_outputs("reset");
      end
      rst_n = 1'b1;

      // No ch_first after release: never locks
      for (int i = 0; i < 20; i++)
         step("unlocked", 1'b1, 1'b0, 6'h3F, rnd16(), rnd16());

      // Basic sum
      for (int s = 0; s < CH; s++)
         step("basic", 1'b1, s == 0, 6'h3F, 1000, -200);
`ifdef JT10_ADPCMA_SAT_EN
      chk("basic.const_l", int'(o_snd_l), 6000);
      chk("basic.const_r", int'(o_snd_r), -1200);
`else
      chk("basic.const_l", int'(o_snd_l), 750);
      chk("basic.const_r", int'(o_snd_r), -150);
`endif
      chk("basic.const_smp", int'(o_snd_sample), 1);

      // Clip / full-scale
      for (int s = 0; s < CH; s++)
         step("clip", 1'b1, s == 0, 6'h3F, 32767, -32768);
`ifdef JT10_ADPCMA_SAT_EN
      chk("clip.const_l", int'(o_snd_l), 32767);
      chk("clip.const_r", int'(o_snd_r), -32768);
`else
      chk("clip.const_l", int'(o_snd_l), 24575);
      chk("clip.const_r", int'(o_snd_r), -24576);
`endif

      // Channel mask
      for (int s = 0; s < CH; s++)
         step("mask", 1'b1, s == 0, 6'b000101, 100 * (s + 1), -7 * (s + 1));
`ifdef JT10_ADPCMA_SAT_EN
      chk("mask.const_l", int'(o_snd_l), 400);
`else
      chk("mask.const_l", int'(o_snd_l), 50);
`endif

      // Mid-round resync at slot 3
      for (int s = 0; s < 3; s++)
         step("pre_resync", 1'b1, s == 0, 6'h3F, 1000, 1000);
      step("resync", 1'b1, 1'b1, 6'h3F, 10, -10);
      chk("resync.const_pulse", int'(o_resync), 1);
      for (int s = 1; s < CH; s++)
         step("post_resync", 1'b1, 1'b0, 6'h3F, 10, -10);
`ifdef JT10_ADPCMA_SAT_EN
      chk("resync.const_l", int'(o_snd_l), 60);
`else
      chk("resync.const_l", int'(o_snd_l), 7);
`endif

      // cen gaps 1-0-0-1 inside a round
      for (int s = 0; s < CH; s++) begin
         step("gap", 1'b1, s == 0, 6'h3F, 1000, -200);
         if (s < CH - 1) begin
            step("gap_idle", 1'b0, 1'b0, 6'h3F, rnd16(), rnd16());
            step("gap_idle", 1'b0, 1'b0, 6'h3F, rnd16(), rnd16());
         end
      end
      step("gap_after", 1'b0, 1'b0, 6'h3F, 0, 0);

      // Random traffic with occasional misplaced ch_first and cen gaps
      for (int i = 0; i < 400; i++) begin
         bit cen   = ($urandom_range(0, 3) != 0);
         bit first = (m_slot == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
         step("rand", cen, first, CH'($urandom), rnd16(), rnd16());
      end

      // Asynchronous reset mid-round
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < CH; k++) slot_vals[k] = rnd16();
      for (int s = 0; s < CH; s++)
         step("pre_arst", 1'b1, s == 0, 6'h3F, slot_vals[s], -slot_vals[s]);
      step("pre_arst2", 1'b1, 1'b1, 6'h3F, 123, 456);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_outputs("arst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++)
         step("arst_unlocked", 1'b1, 1'b0, 6'h3F, rnd16(), rnd16());
      for (int s = 0; s < CH; s++)
         step("arst_relock", 1'b1, s == 0, 6'h3F, rnd16(), rnd16());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_jt10_adpcma_mix
